switch_box_cfg: RTL
===================

// Module: switch_box_cfg
// PURPOSE
//  Parametrised FPGA routing switch box with a run-time serial configuration port. Each track on
//  the four sides (top/right/bottom/left) is driven from one selected track, or left at Z.
//  Routing words load via a bit-serial valid/ready stream into a shadow chain, are range- and
//  self-loop-checked on commit, then swapped atomically into the active routing set. Sits in the
//  routing fabric between logic tiles; the chain is fed by the device configuration loader.
// PARAMETERS
//  NTB   5  tracks on top and bottom sides each
//  NLR   4  tracks on left and right sides each
//  IDXW  3  track-index field width; must be >= clog2(max(NTB,NLR))
//  Derived: CFGW=IDXW+3 bits/entry; NENT=2*NTB+2*NLR; NBITS=NENT*CFGW (108 at defaults)
// PORTS
//  clk         in     1     configuration clock
//  rst_n       in     1     asynchronous active-low reset
//  wtop        inout  NTB   top tracks
//  wright      inout  NLR   right tracks
//  wbottom     inout  NTB   bottom tracks
//  wleft       inout  NLR   left tracks
//  cfg_start   in     1     pulse: clear bit counter, enter SHIFT
//  cfg_din     in     1     serial config bit
//  cfg_valid   in     1     cfg_din valid
//  cfg_ready   out    1     chain accepts a bit (transfer when valid&ready)
//  cfg_dout    out    1     readback: shadow bit 0 (bit shifted out on next transfer)
//  cfg_commit  in     1     pulse: check and apply shadow
//  cfg_done    out    1     one-cycle pulse: shadow applied
//  cfg_err     out    1     sticky: last commit rejected; cleared by cfg_start
// BEHAVIOUR
//  Entry: [2:0] side sel (0 none/Z, 1 top, 2 right, 3 bottom, 4 left, 5-7 Z); [CFGW-1:3] index.
//  Entry order: top[0..NTB-1], right[0..NLR-1], bottom[0..NTB-1], left[0..NLR-1]; entry k at
//   shadow[k*CFGW +: CFGW]. Transfer: shadow <= {cfg_din, shadow[NBITS-1:1]}; first bit sent
//   ends at bit 0 of entry 0.
//  Track drive is combinational from the active set: track = selected source track, else Z.
//  FSM: IDLE (ready=0) -cfg_start-> SHIFT (ready=1; count++ per transfer; at count==NBITS ->
//   FULL) ; FULL (ready=0) -cfg_commit-> CHECK ; CHECK (1 cycle) -> IDLE.
//  CHECK: entry invalid if sel in 1..4 and index >= that side's track count, or entry selects
//   itself (same side, same index). Any invalid: cfg_err<=1, active unchanged. Else active<=
//   shadow, cfg_done pulses. Routing changes exactly 2 clocks after commit sampled in FULL.
//  cfg_commit outside FULL ignored. cfg_start in any state restarts (count=0, SHIFT, err=0);
//   active unchanged. start+commit same cycle: start wins. Transfers only in SHIFT.
//  Reset (any time, incl. mid-shift/CHECK): state IDLE, count 0, shadow 0, active 0 (all tracks
//   Z), cfg_ready 0, cfg_done 0, cfg_err 0, cfg_dout 0.
//  Counter width clog2(NBITS+1); no wrap: ready drops at NBITS, extra valid bits are not taken.
// STRUCTURE
//  Package switch_box_pkg: side codes SIDE_NONE/TOP/RIGHT/BOTTOM/LEFT, FSM state enum.
//  Sub-module sb_track_mux: one per track; inputs sel/index and all four side buses, output
//   one tristate-capable drive value; instanced NENT times in generate loops.
// TESTING
//  Reset: rst_n=0 -> all tracks Z, cfg_ready=0, cfg_done=0, cfg_err=0.
//  Load 108 bits, top[0]=6'b001_010, rest 0; commit -> cfg_done 2 clks later; wtop[0] follows
//   wright[1] (drive wright[1]=1/0), all other tracks Z.
//  Self-loop top[2]=6'b010_001 -> cfg_err=1, no cfg_done, previous routing retained.
//  Out of range right[0]=6'b101_001 (top idx 5) -> cfg_err=1; cfg_start clears cfg_err.
//  Backpressure: valid held after 108 bits -> ready=0, count stays 108; readback cfg_dout
//   during a second load returns the first load's bits in order.
//  rst_n low mid-SHIFT (bit 50) and during CHECK -> routing all Z, FSM IDLE, no cfg_done.

Source files
------------

// File: rtl/switch_box_pkg.sv
// Shared side codes and configuration FSM states for the switch box.
package switch_box_pkg;
    localparam int SELW = 3;

    typedef enum logic [SELW-1:0] {
        SIDE_NONE   = 3'd0,
        SIDE_TOP    = 3'd1,
        SIDE_RIGHT  = 3'd2,
        SIDE_BOTTOM = 3'd3,
        SIDE_LEFT   = 3'd4
    } side_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FULL,
        ST_CHECK
    } state_e;
endpackage

// File: rtl/sb_track_mux.sv
// One track's source selector: picks a track from the requested side, or requests no drive.
module sb_track_mux
    import switch_box_pkg::*;
#(
    parameter int NTB  = 5,
    parameter int NLR  = 4,
    parameter int IDXW = 3
) (
    input  logic [SELW-1:0] i_sel,
    input  logic [IDXW-1:0] i_idx,
    input  logic [NTB-1:0]  i_top,
    input  logic [NLR-1:0]  i_right,
    input  logic [NTB-1:0]  i_bottom,
    input  logic [NLR-1:0]  i_left,
    output logic            o_en,
    output logic            o_val
);
    // Index compared per track so an index wider than the side never reads past the bus.
    always_comb begin
        o_en  = 1'b0;
        o_val = 1'b0;
        case (i_sel)
            SIDE_TOP:
                for (int j = 0; j < NTB; j++)
                    if (i_idx == IDXW'(j)) begin o_en = 1'b1; o_val = i_top[j]; end
            SIDE_RIGHT:
                for (int j = 0; j < NLR; j++)
                    if (i_idx == IDXW'(j)) begin o_en = 1'b1; o_val = i_right[j]; end
            SIDE_BOTTOM:
                for (int j = 0; j < NTB; j++)
                    if (i_idx == IDXW'(j)) begin o_en = 1'b1; o_val = i_bottom[j]; end
            SIDE_LEFT:
                for (int j = 0; j < NLR; j++)
                    if (i_idx == IDXW'(j)) begin o_en = 1'b1; o_val = i_left[j]; end
            default: ;
        endcase
    end
endmodule

// File: rtl/switch_box_cfg.sv
// Routing switch box: serial shadow chain, commit-time legality check, atomic swap into active set.
module switch_box_cfg
    import switch_box_pkg::*;
#(
    parameter int NTB  = 5,
    parameter int NLR  = 4,
    parameter int IDXW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    inout  wire [NTB-1:0]  wtop,
    inout  wire [NLR-1:0]  wright,
    inout  wire [NTB-1:0]  wbottom,
    inout  wire [NLR-1:0]  wleft,
    input  logic           cfg_start,
    input  logic           cfg_din,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    output logic           cfg_dout,
    input  logic           cfg_commit,
    output logic           cfg_done,
    output logic           cfg_err
);
    localparam int CFGW  = IDXW + SELW;
    localparam int NENT  = 2*NTB + 2*NLR;
    localparam int NBITS = NENT * CFGW;
    localparam int CNTW  = $clog2(NBITS + 1);

    state_e           r_state, w_nxt;
    logic [CNTW-1:0]  r_cnt;
    logic [NBITS-1:0] r_shadow, r_active;
    logic             r_done, r_err, w_xfer;
    logic [NENT-1:0]  w_bad;

    assign cfg_ready = (r_state == ST_SHIFT);
    assign cfg_dout  = r_shadow[0];
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;

    always_comb begin
        w_nxt  = r_state;
        w_xfer = 1'b0;
        if (cfg_start) begin
            w_nxt = ST_SHIFT;
        end else begin
            case (r_state)
                ST_SHIFT: if (cfg_valid) begin
                    w_xfer = 1'b1;
                    if (r_cnt == CNTW'(NBITS - 1)) w_nxt = ST_FULL;
                end
                ST_FULL:  if (cfg_commit) w_nxt = ST_CHECK;
                ST_CHECK: w_nxt = ST_IDLE;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_active <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_done  <= 1'b0;
            // A restart pre-empts both shifting and a pending apply.
            if (cfg_start) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end else if (w_xfer) begin
                r_cnt    <= r_cnt + 1'b1;
                r_shadow <= {cfg_din, r_shadow[NBITS-1:1]};
            end else if (r_state == ST_CHECK) begin
                if (|w_bad) begin
                    r_err <= 1'b1;
                end else begin
                    r_active <= r_shadow;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NENT; k++) begin : g_ent
        localparam int SIDE = (k < NTB) ? 1 : (k < NTB+NLR) ? 2 : (k < 2*NTB+NLR) ? 3 : 4;
        localparam int BASE = (SIDE == 1) ? 0 : (SIDE == 2) ? NTB :
                              (SIDE == 3) ? NTB+NLR : 2*NTB+NLR;
        localparam int OIDX = k - BASE;

        logic [SELW-1:0] w_ssel;
        logic [IDXW-1:0] w_sidx;
        logic            w_range, w_self, w_en, w_val;

        assign w_ssel  = r_shadow[k*CFGW +: SELW];
        assign w_sidx  = r_shadow[k*CFGW+SELW +: IDXW];
        assign w_range = ((w_ssel == SIDE_TOP || w_ssel == SIDE_BOTTOM) && int'(w_sidx) >= NTB) ||
                         ((w_ssel == SIDE_RIGHT || w_ssel == SIDE_LEFT) && int'(w_sidx) >= NLR);
        assign w_self  = (w_ssel == SELW'(SIDE)) && (w_sidx == IDXW'(OIDX));
        assign w_bad[k] = w_range | w_self;

        sb_track_mux #(.NTB(NTB), .NLR(NLR), .IDXW(IDXW)) u_mux (
            .i_sel    (r_active[k*CFGW +: SELW]),
            .i_idx    (r_active[k*CFGW+SELW +: IDXW]),
            .i_top    (wtop),
            .i_right  (wright),
            .i_bottom (wbottom),
            .i_left   (wleft),
            .o_en     (w_en),
            .o_val    (w_val)
        );

        if (SIDE == 1) begin : g_t
            assign wtop[OIDX] = w_en ? w_val : 1'bz;
        end else if (SIDE == 2) begin : g_r
            assign wright[OIDX] = w_en ? w_val : 1'bz;
        end else if (SIDE == 3) begin : g_b
            assign wbottom[OIDX] = w_en ? w_val : 1'bz;
        end else begin : g_l
            assign wleft[OIDX] = w_en ? w_val : 1'bz;
        end
    end
endmodule
